serial_sram_ctrl_burst: RTL and testbench

//  Parametrised pin-level serial access controller for the on-chip instruction/data SRAM.

---
 rtl/serial_sram_ctrl_burst.sv | 172 +++++++++++++++++
 tb/tb_serial_sram_ctrl_burst.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sram_ctrl_burst.sv
// Pin-level serial access controller for the on-chip SRAM: shifts {addr,data} over a
// LOAD_N/CTRL_RDY handshake and runs SRAM reads, writes and post-increment bursts.
module serial_sram_ctrl_burst #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 9,
   parameter int RD_LAT       = 1,
   parameter int SYNC_STAGES  = 2,
   parameter int READ_POSTINC = 0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [1:0]            CTRL_MODE,
   input  logic                  LOAD_N,
   input  logic                  CTRL_SI,
   input  logic                  CPU_OWN,
   output logic                  CTRL_RDY,
   output logic                  CTRL_SO,
   output logic                  CTRL_ERR,
   output logic                  SRAM_CEN,
   output logic                  SRAM_WEN,
   output logic [ADDR_WIDTH-1:0] SRAM_A,
   output logic [DATA_WIDTH-1:0] SRAM_D,
   input  logic [DATA_WIDTH-1:0] SRAM_Q
);

   localparam int REG_W = ADDR_WIDTH + DATA_WIDTH;
   localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

   localparam logic [1:0] MODE_SHIFT     = 2'b00;
   localparam logic [1:0] MODE_READ      = 2'b01;
   localparam logic [1:0] MODE_WRITE_INC = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      WR,
      RD,
      RWAIT,
      DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [REG_W-1:0]       shreg_q, shreg_d;
   logic [1:0]             mode_q, mode_d;
   logic                   si_q, si_d;
   logic [1:0]             cnt_q, cnt_d;
   logic                   cen_q, cen_d;
   logic                   wen_q, wen_d;
   logic                   rdy_q, rdy_d;
   logic                   err_q, err_d;
   logic [SYNC_STAGES-1:0] ld_sync;
   logic                   ld_q;
   logic                   ld_s;
   logic                   req;

   // Sync flops reset low so a LOAD_N held low through reset never looks like a falling edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         ld_sync <= '0;
         ld_q    <= 1'b0;
      end else begin
         ld_sync <= {ld_sync[SYNC_STAGES-2:0], LOAD_N};
         ld_q    <= ld_s;
      end
   end

   assign ld_s = ld_sync[SYNC_STAGES-1];
   assign req  = !ld_s && ld_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         shreg_q <= '0;
         mode_q  <= MODE_SHIFT;
         si_q    <= 1'b0;
         cnt_q   <= 2'd0;
         cen_q   <= 1'b1;
         wen_q   <= 1'b1;
         rdy_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         mode_q  <= mode_d;
         si_q    <= si_d;
         cnt_q   <= cnt_d;
         cen_q   <= cen_d;
         wen_q   <= wen_d;
         rdy_q   <= rdy_d;
         err_q   <= err_d;
      end
   end

   // Strobes are decided one state early so they come straight out of flops.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      mode_d  = mode_q;
      si_d    = si_q;
      cnt_d   = cnt_q;
      cen_d   = 1'b1;
      wen_d   = 1'b1;
      err_d   = err_q;

      unique case (state_q)
         IDLE: begin
            if (req) begin
               mode_d = CTRL_MODE;
               si_d   = CTRL_SI;
               if (CTRL_MODE == MODE_SHIFT) begin
                  state_d = SHIFT;
               end else if (CPU_OWN) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  err_d = 1'b0;
                  cen_d = 1'b0;
                  if (CTRL_MODE == MODE_READ) begin
                     state_d = RD;
                  end else begin
                     wen_d   = 1'b0;
                     state_d = WR;
                  end
               end
            end
         end
         SHIFT: begin
            shreg_d = {si_q, shreg_q[REG_W-1:1]};
            state_d = DONE;
         end
         WR: begin
            if (mode_q == MODE_WRITE_INC) begin
               shreg_d[REG_W-1:DATA_WIDTH] = shreg_q[REG_W-1:DATA_WIDTH] + ADDR_ONE;
            end
            state_d = DONE;
         end
         RD: begin
            cnt_d   = 2'd0;
            state_d = RWAIT;
         end
         RWAIT: begin
            if (cnt_q == LAST_WAIT) begin
               shreg_d[DATA_WIDTH-1:0] = SRAM_Q;
               if (READ_POSTINC != 0) begin
                  shreg_d[REG_W-1:DATA_WIDTH] = shreg_q[REG_W-1:DATA_WIDTH] + ADDR_ONE;
               end
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         DONE: begin
            if (ld_s) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      rdy_d = (state_d == DONE);
   end

   assign CTRL_RDY = rdy_q;
   assign CTRL_SO  = shreg_q[0];
   assign CTRL_ERR = err_q;
   assign SRAM_CEN = cen_q;
   assign SRAM_WEN = wen_q;
   assign SRAM_A   = shreg_q[REG_W-1:DATA_WIDTH];
   assign SRAM_D   = shreg_q[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_serial_sram_ctrl_burst.sv
// Directed bench for serial_sram_ctrl_burst: instance 0 uses defaults (RD_LAT=1),
// instance 1 uses RD_LAT=3 with READ_POSTINC=1. Each has its own SRAM model.
module tb_serial_sram_ctrl_burst;

   logic       clk = 1'b0;
   logic       rst;
   logic       load_n [2];
   logic       si     [2];
   logic       own    [2];
   logic [1:0] mode   [2];
   logic       rdy    [2];
   logic       so     [2];
   logic       err    [2];
   logic       cen    [2];
   logic       wen    [2];
   logic [8:0] a      [2];
   logic [7:0] d      [2];
   logic [7:0] q      [2];

   logic [7:0] mem     [2][512];
   logic [7:0] pipe    [2][3];
   int         wr_cnt  [2];
   int         cen_cnt [2];
   logic [8:0] last_wa [2];
   logic [7:0] last_wd [2];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   serial_sram_ctrl_burst dut0 (
      .CLK(clk), .RST(rst), .CTRL_MODE(mode[0]), .LOAD_N(load_n[0]), .CTRL_SI(si[0]),
      .CPU_OWN(own[0]), .CTRL_RDY(rdy[0]), .CTRL_SO(so[0]), .CTRL_ERR(err[0]),
      .SRAM_CEN(cen[0]), .SRAM_WEN(wen[0]), .SRAM_A(a[0]), .SRAM_D(d[0]), .SRAM_Q(q[0])
   );

   serial_sram_ctrl_burst #(.RD_LAT(3), .READ_POSTINC(1)) dut1 (
      .CLK(clk), .RST(rst), .CTRL_MODE(mode[1]), .LOAD_N(load_n[1]), .CTRL_SI(si[1]),
      .CPU_OWN(own[1]), .CTRL_RDY(rdy[1]), .CTRL_SO(so[1]), .CTRL_ERR(err[1]),
      .SRAM_CEN(cen[1]), .SRAM_WEN(wen[1]), .SRAM_A(a[1]), .SRAM_D(d[1]), .SRAM_Q(q[1])
   );

   // SRAM models: read data appears RD_LAT cycles after the CEN-low edge, valid for one cycle only.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!cen[i]) cen_cnt[i] <= cen_cnt[i] + 1;
         if (!cen[i] && !wen[i]) begin
            mem[i][a[i]] <= d[i];
            wr_cnt[i]    <= wr_cnt[i] + 1;
            last_wa[i]   <= a[i];
            last_wd[i]   <= d[i];
         end
         pipe[i][0] <= (!cen[i] && wen[i]) ? mem[i][a[i]] : 8'hEE;
         pipe[i][1] <= pipe[i][0];
         pipe[i][2] <= pipe[i][1];
      end
   end

   assign q[0] = pipe[0][0];
   assign q[1] = pipe[1][2];

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // One full handshake; lat counts rising edges from LOAD_N falling until RDY is seen.
   task automatic applyStimulus(input int sel, input logic [1:0] md, input logic s,
                                input logic ow, output int lat);
      int n;
      @(negedge clk);
      mode[sel]   = md;
      si[sel]     = s;
      own[sel]    = ow;
      load_n[sel] = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!rdy[sel] && lat < 30);
      if (!rdy[sel]) checkOutput("rdy_timeout", 32'(rdy[sel]), 32'd1);
      load_n[sel] = 1'b1;
      n = 0;
      while (rdy[sel] && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (rdy[sel]) checkOutput("rdy_release_timeout", 32'(rdy[sel]), 32'd0);
      @(negedge clk);
   endtask

   task automatic shift_word(input int sel, input logic [16:0] v);
      int lat;
      for (int i = 0; i < 17; i++) applyStimulus(sel, 2'b00, v[i], 1'b0, lat);
   endtask

   initial begin
      int         lat;
      int         wr_snap;
      int         cen_snap;
      logic       saw_rdy;
      logic [7:0] so_bits;
      logic [8:0] ea;
      logic [7:0] wdata [4];

      wdata = '{8'hA5, 8'h5A, 8'h3C, 8'hC3};
      for (int i = 0; i < 2; i++) begin
         load_n[i] = 1'b1;
         si[i]     = 1'b0;
         own[i]    = 1'b0;
         mode[i]   = 2'b00;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         checkOutput("reset_cen", 32'(cen[i]), 32'd1);
         checkOutput("reset_wen", 32'(wen[i]), 32'd1);
         checkOutput("reset_rdy", 32'(rdy[i]), 32'd0);
         checkOutput("reset_err", 32'(err[i]), 32'd0);
         checkOutput("reset_shreg", 32'({a[i], d[i]}), 32'd0);
      end
      rst = 1'b0;
      repeat (5) @(negedge clk);

      $display("[TB] write of 8'h0C to 9'h020");
      shift_word(0, {9'h020, 8'h0C});
      checkOutput("t1_shift_a", 32'(a[0]), 32'h020);
      checkOutput("t1_shift_d", 32'(d[0]), 32'h0C);
      wr_snap  = wr_cnt[0];
      cen_snap = cen_cnt[0];
      applyStimulus(0, 2'b11, 1'b0, 1'b0, lat);
      checkOutput("t1_write_latency", 32'(lat), 32'd4);
      checkOutput("t1_write_count", 32'(wr_cnt[0] - wr_snap), 32'd1);
      checkOutput("t1_cen_cycles", 32'(cen_cnt[0] - cen_snap), 32'd1);
      checkOutput("t1_write_addr", 32'(last_wa[0]), 32'h020);
      checkOutput("t1_write_data", 32'(last_wd[0]), 32'h0C);

      $display("[TB] read back from 9'h020");
      shift_word(0, {9'h020, 8'h00});
      applyStimulus(0, 2'b01, 1'b0, 1'b0, lat);
      checkOutput("t2_read_latency", 32'(lat), 32'd5);
      checkOutput("t2_read_data", 32'(d[0]), 32'h0C);
      checkOutput("t2_read_addr", 32'(a[0]), 32'h020);
      for (int i = 0; i < 8; i++) begin
         so_bits[i] = so[0];
         applyStimulus(0, 2'b00, 1'b0, 1'b0, lat);
      end
      checkOutput("t2_serial_out", 32'(so_bits), 32'h0C);

      $display("[TB] write-increment burst across the address wrap");
      shift_word(0, {9'h1FE, wdata[0]});
      for (int k = 0; k < 4; k++) begin
         ea = 9'h1FE + 9'(k);
         applyStimulus(0, 2'b10, 1'b0, 1'b0, lat);
         checkOutput("t3_burst_addr", 32'(last_wa[0]), 32'(ea));
         checkOutput("t3_burst_data", 32'(last_wd[0]), 32'(wdata[k]));
         checkOutput("t3_next_addr", 32'(a[0]), 32'(9'(ea + 9'd1)));
         if (k < 3) shift_word(0, {9'(ea + 9'd1), wdata[k + 1]});
      end
      checkOutput("t3_final_addr", 32'(a[0]), 32'h002);
      checkOutput("t3_mem_1fe", 32'(mem[0][9'h1FE]), 32'hA5);
      checkOutput("t3_mem_1ff", 32'(mem[0][9'h1FF]), 32'h5A);
      checkOutput("t3_mem_000", 32'(mem[0][9'h000]), 32'h3C);
      checkOutput("t3_mem_001", 32'(mem[0][9'h001]), 32'hC3);

      $display("[TB] CPU ownership lockout");
      cen_snap = cen_cnt[0];
      applyStimulus(0, 2'b11, 1'b0, 1'b1, lat);
      checkOutput("t4_no_strobe", 32'(cen_cnt[0] - cen_snap), 32'd0);
      checkOutput("t4_err_set", 32'(err[0]), 32'd1);
      checkOutput("t4_shreg_kept", 32'({a[0], d[0]}), 32'({9'h002, 8'hC3}));
      applyStimulus(0, 2'b01, 1'b0, 1'b0, lat);
      checkOutput("t4_err_clear", 32'(err[0]), 32'd0);
      applyStimulus(0, 2'b11, 1'b0, 1'b1, lat);
      checkOutput("t4_err_set_again", 32'(err[0]), 32'd1);

      $display("[TB] reset during read wait with LOAD_N held low");
      @(negedge clk);
      mode[0]   = 2'b01;
      own[0]    = 1'b0;
      load_n[0] = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("t5_cen", 32'(cen[0]), 32'd1);
      checkOutput("t5_rdy", 32'(rdy[0]), 32'd0);
      checkOutput("t5_err", 32'(err[0]), 32'd0);
      checkOutput("t5_shreg", 32'({a[0], d[0]}), 32'd0);
      cen_snap = cen_cnt[0];
      saw_rdy  = 1'b0;
      repeat (10) begin
         @(negedge clk);
         saw_rdy |= rdy[0];
      end
      checkOutput("t5_no_op_rdy", 32'(saw_rdy), 32'd0);
      checkOutput("t5_no_op_cen", 32'(cen_cnt[0] - cen_snap), 32'd0);
      load_n[0] = 1'b1;
      repeat (4) @(negedge clk);
      applyStimulus(0, 2'b00, 1'b1, 1'b0, lat);
      checkOutput("t5_fresh_latency", 32'(lat), 32'd4);
      checkOutput("t5_fresh_shift", 32'(a[0]), 32'h100);

      $display("[TB] post-increment read with RD_LAT=3");
      shift_word(1, {9'h0FF, 8'h77});
      applyStimulus(1, 2'b11, 1'b0, 1'b0, lat);
      checkOutput("t6_write_addr", 32'(last_wa[1]), 32'h0FF);
      shift_word(1, {9'h0FF, 8'h00});
      applyStimulus(1, 2'b01, 1'b0, 1'b0, lat);
      checkOutput("t6_read_latency", 32'(lat), 32'd7);
      checkOutput("t6_read_data", 32'(d[1]), 32'h77);
      checkOutput("t6_postinc_addr", 32'(a[1]), 32'h100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
